// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divider: data bus width, zero word,
// controller state encoding, iteration counter width and a magnitude helper.
package div_ctrl_pkg;

    localparam int DataBus = 32;
    localparam logic [DataBus-1:0] ZeroWord = '0;
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        DIV_IDLE  = 3'd0,
        DIV_PREP  = 3'd1,
        DIV_CALC  = 3'd2,
        DIV_FIXUP = 3'd3,
        DIV_DONE  = 3'd4
    } div_state_e;

    // Two's-complement magnitude; only negates when the operation is signed.
    function automatic logic [DataBus-1:0] magnitude(input logic is_signed,
                                                     input logic [DataBus-1:0] x);
        return (is_signed && x[DataBus-1]) ? (ZeroWord - x) : x;
    endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring division iteration (purely combinational).
// The remainder:quotient pair is shifted left by one; the divisor is
// subtracted when it fits, and the resulting quotient bit is shifted in.
module div_step
    import div_ctrl_pkg::*;
(
    input  logic [DataBus:0]   rem,
    input  logic [DataBus-1:0] quo,
    input  logic [DataBus-1:0] dvs,
    output logic [DataBus:0]   rem_next,
    output logic [DataBus-1:0] quo_next
);

    logic [DataBus+1:0] shifted;
    logic [DataBus:0]   diff;
    logic               fits;

    // Trial subtraction; the comparison decides, so the difference never wraps when used
    always_comb begin
        shifted  = {rem, quo[DataBus-1]};
        fits     = (shifted >= {2'b00, dvs});
        diff     = shifted[DataBus:0] - {1'b0, dvs};
        rem_next = fits ? diff : shifted[DataBus:0];
        quo_next = {quo[DataBus-2:0], fits};
    end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer for the EX stage: 32-step restoring division on operand
// magnitudes, MIPS sign fix-up, one-cycle done pulse, busy stall request.
// Optional macro DIV_EARLY_DONE_EN: finish in PREP when |dividend| < |divisor|.
// Only DW = 32 is supported.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DW = 32
)
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          sign,
    input  logic [DW-1:0] opr1,
    input  logic [DW-1:0] opr2,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] lo,
    output logic [DW-1:0] hi
);

    div_state_e state, state_next;

    logic [CNT_W-1:0]   cnt;
    logic [DataBus:0]   rem, rem_next;
    logic [DataBus-1:0] quo, quo_next;
    logic [DataBus-1:0] dvd_mag, dvs_mag;
    logic               sign_r, neg1, neg2;
    logic [DataBus-1:0] lo_fix, hi_fix;

`ifdef DIV_EARLY_DONE_EN
    logic [DataBus-1:0] opr1_r;
    logic               early;
    // A zero divisor can never satisfy this, so division by zero takes the long path
    assign early = (dvd_mag < dvs_mag);
`endif

    div_step u_step (
        .rem      (rem),
        .quo      (quo),
        .dvs      (dvs_mag),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Quotient takes the XOR of operand signs; remainder follows the dividend sign
    assign lo_fix = (sign_r && (neg1 ^ neg2)) ? (ZeroWord - quo) : quo;
    assign hi_fix = (sign_r && neg1) ? (ZeroWord - rem[DataBus-1:0]) : rem[DataBus-1:0];

    // State register, iteration counter and registered results (flush leaves results untouched)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            lo    <= ZeroWord;
            hi    <= ZeroWord;
        end else begin
            state <= state_next;
            if (state == DIV_PREP) begin
                cnt <= '0;
            end else if (state == DIV_CALC) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (!flush) begin
                if (state == DIV_FIXUP) begin
                    lo <= lo_fix;
                    hi <= hi_fix;
                end
`ifdef DIV_EARLY_DONE_EN
                else if (state == DIV_PREP && early) begin
                    lo <= ZeroWord;
                    hi <= opr1_r;
                end
`endif
            end
        end
    end

    // Next-state logic and status outputs; flush overrides everything
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start) state_next = DIV_PREP;
            end
            DIV_PREP: begin
                busy       = 1'b1;
                state_next = DIV_CALC;
`ifdef DIV_EARLY_DONE_EN
                if (early) state_next = DIV_DONE;
`endif
            end
            DIV_CALC: begin
                busy = 1'b1;
                if (cnt == '1) state_next = DIV_FIXUP;
            end
            DIV_FIXUP: begin
                busy       = 1'b1;
                state_next = DIV_DONE;
            end
            DIV_DONE: begin
                done       = 1'b1;
                state_next = DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase
        if (flush) state_next = DIV_IDLE;
    end

    // Operand capture in IDLE and the iterated remainder/quotient datapath
    always_ff @(posedge clk) begin
        if (state == DIV_IDLE && start && !flush) begin
            sign_r  <= sign;
            neg1    <= opr1[DW-1];
            neg2    <= opr2[DW-1];
            dvd_mag <= magnitude(sign, opr1);
            dvs_mag <= magnitude(sign, opr2);
`ifdef DIV_EARLY_DONE_EN
            opr1_r  <= opr1;
`endif
        end
        if (state == DIV_PREP) begin
            rem <= '0;
            quo <= dvd_mag;
        end else if (state == DIV_CALC) begin
            rem <= rem_next;
            quo <= quo_next;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases, flush and reset
// scenarios, then random divisions checked against an arithmetic model.
module tb_div_ctrl;

`ifdef DIV_EARLY_DONE_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        sign;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;

    int n_cmp = 0;
    int n_err = 0;

    div_ctrl #(.DW(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .sign   (sign),
        .opr1   (opr1),
        .opr2   (opr2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .lo     (lo),
        .hi     (hi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: mathematical truncating division with the MIPS divide-by-zero outcome
    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo_e, output logic [31:0] hi_e,
                                  output int lat_e);
        longint sa, sb, q, r;
        logic [31:0] ma, mb;
        ma = (sgn && a[31]) ? (32'd0 - a) : a;
        mb = (sgn && b[31]) ? (32'd0 - b) : b;
        lat_e = (EARLY_EN && (ma < mb)) ? 2 : 35;
        if (b == 32'd0) begin
            hi_e = a;
            lo_e = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (!sgn) begin
            lo_e = a / b;
            hi_e = a % b;
        end else begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            q  = sa / sb;
            r  = sa % sb;
            lo_e = q[31:0];
            hi_e = r[31:0];
        end
    endfunction

    task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b);
        logic [31:0] lo_e, hi_e;
        int lat_e, lat, bsy;
        bit seen;
        model(sgn, a, b, lo_e, hi_e, lat_e);
        @(negedge clk);
        start = 1'b1; sign = sgn; opr1 = a; opr2 = b;
        lat = 0; bsy = 0; seen = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            if (busy) bsy++;
        end
        chk({tag, ".done_seen"}, 32'(seen), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(lat_e));
        chk({tag, ".busy_cycles"}, 32'(bsy), 32'(lat_e - 1));
        chk({tag, ".lo"}, lo, lo_e);
        chk({tag, ".hi"}, hi, hi_e);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".lo_hold"}, lo, lo_e);
    endtask

    initial begin
        logic [31:0] a, b;
        bit sgn;

        resetn = 1'b0; start = 1'b0; sign = 1'b0; opr1 = '0; opr2 = '0; flush = 1'b0;
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.hi", hi, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0);
        run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
        run_div("divu_3_10", 1'b0, 32'd3, 32'd10);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);

        // Flush during CALC: previous result (7 / -2 -> lo -3, hi 1) must survive
        @(negedge clk);
        start = 1'b1; sign = 1'b0; opr1 = 32'd1000; opr2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush.busy", 32'(busy), 32'd0);
        chk("flush.done", 32'(done), 32'd0);
        chk("flush.lo", lo, 32'hFFFF_FFFD);
        chk("flush.hi", hi, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("flush.no_done", 32'(done), 32'd0);
        end
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3);

        // Asynchronous reset mid-CALC, then a normal request
        @(negedge clk);
        start = 1'b1; sign = 1'b0; opr1 = 32'd77; opr2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        chk("arst.lo", lo, 32'd0);
        chk("arst.hi", hi, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_div("after_rst", 1'b0, 32'd100, 32'd7);

        // Random mix of signed/unsigned with small, large and zero operands
        for (int k = 0; k < 20; k++) begin
            sgn = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
            run_div("rand", sgn, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
